stack_ctl: RTL
==============

Name: stack_ctl

Overview:
TOS-cached stack front-end: initiator side of the stack bus, driving an EBR stack RAM (op, sp, vi) and consuming its read data.
- Keeps the top-of-stack in a register; only NOS and below live in RAM.
- Offers the Forth core a valid/ready op port and an always-valid TOS output.
- Tracks depth and flags overflow/underflow.

Parameters:
DEPTH, 64, total capacity including cached TOS; RAM holds DEPTH-1 entries
DSZ, 32, data width
SSZ, $clog2(DEPTH), RAM address width
RD_LAT, 1, cycles from address issue to valid ram_q (>=1)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  reset, synchronous, active-high
req_valid  in  1  core op request
req_ready  out  1  controller can accept op
req_op  in  2  stack_op_t: NOP/PUSH/POP/REPL
req_vi  in  DSZ  value for PUSH/REPL
tos  out  DSZ  current top of stack (0 when empty)
depth  out  SSZ+1  entries held, 0..DEPTH
empty  out  1  depth==0
full  out  1  depth==DEPTH
ovf  out  1  sticky overflow
unf  out  1  sticky underflow
err_clr  in  1  clears ovf/unf
ram_en  out  1  RAM clock enable
ram_op  out  2  stack_op_t to RAM (PUSH=write, POP=read, NOP)
ram_sp  out  SSZ  RAM address
ram_vi  out  DSZ  RAM write data
ram_q  in  DSZ  RAM read data

Behaviour:
- Reset: state IDLE, tos=0, depth=0, ovf=unf=0, req_ready=1, ram_en=0, ram_op=NOP, ram_sp=0, ram_vi=0.
- RAM layout: entry k below TOS (k=1 is NOS) at address depth-1-k. NOS address = depth-2.
- Accept = req_valid && req_ready. NOP accepted with no effect.
- PUSH, depth==0: tos<=req_vi, depth<=1, no RAM access.
- PUSH, 1<=depth<DEPTH: in the accept cycle drive ram_en=1, ram_op=PUSH, ram_sp=depth-1, ram_vi=tos. Registered update: tos<=req_vi, depth++. Single cycle; ready stays 1.
- PUSH, depth==DEPTH: accepted and dropped; ovf<=1; no other state change.
- POP, depth==1: tos<=0, depth<=0, no RAM access.
- POP, depth>=2:
  - Accept cycle drives ram_en=1, ram_op=POP, ram_sp=depth-2.
  - Next state RD; ram_op/ram_sp held for RD_LAT cycles with req_ready=0.
  - At the end of the RD_LAT-th cycle: tos<=ram_q, depth--, return to IDLE.
  - Total occupancy is 1+RD_LAT cycles.
- POP, depth==0: accepted and dropped; unf<=1.
- REPL: tos<=req_vi if depth>=1, single cycle, no RAM access. If depth==0, unf<=1 and no change.
- FSM states: IDLE, RD. RD has an internal counter 0..RD_LAT-1 and only exits to IDLE. No back-to-back overlap.
- Flags and status:
  - err_clr clears ovf/unf; a new error in the same cycle wins (flag stays 1).
  - empty/full/depth are registered-state derived, combinational from depth.
- Address math is SSZ-bit. No wrap-around is possible because depth is bounded by the full/empty checks.
- rst in RD: read abandoned, all reset values restored next cycle.
- Core must hold req_op/req_vi stable only in the accept cycle.

Optional Feature:
STACK_HWM_EN
- Defined: extra output hwm [SSZ+1], reset 0, updated to max(hwm, depth) every cycle; err_clr does not clear it.
- Undefined: port and register absent.

Decomposition:
- Shared package (forthsuper package): stack_op_t enum (NOP=0, PUSH=1, POP=2, REPL=3), shared with the RAM-side stack block.
- Constants: default DEPTH/DSZ.
- Natural sub-module: stack_ctl_fsm (IDLE/RD sequencing, RD_LAT counter, req_ready). The datapath stays in stack_ctl.

Test Plan:
- Reset then PUSH 5, PUSH 7, PUSH 9 -> tos=9, depth=3; RAM writes addr0=5, addr1=7; req_ready never drops.
- From {5,7,9}, POP, POP -> each POP holds req_ready=0 for RD_LAT cycles; tos=7 then 5; ram_sp=1 then 0; depth=1; third POP -> tos=0, empty=1, no ram_en.
- POP on empty -> unf=1, depth=0, tos=0. Then err_clr together with another empty POP -> unf stays 1. err_clr alone -> unf=0.
- Fill with DEPTH PUSHes of 1..64, then PUSH 99 -> full=1, ovf=1, tos=64, depth=64; POP -> tos=63, full=0.
- REPL 42 at depth 2 -> tos=42, depth=2, no RAM access. REPL on empty -> unf=1.
- Assert rst during RD of a POP at depth 3 -> next cycle depth=0, tos=0, req_ready=1, ram_op=NOP. With STACK_HWM_EN, hwm=3 before reset and 0 after.

Source files
------------

// File: rtl/stack_ctl_pkg.sv
// Shared definitions for the TOS-cached stack controller and the RAM-side stack block.
package stack_ctl_pkg;

  localparam int unsigned STACK_DEPTH = 64;
  localparam int unsigned STACK_DSZ   = 32;

  typedef enum logic [1:0] {
    NOP  = 2'd0,
    PUSH = 2'd1,
    POP  = 2'd2,
    REPL = 2'd3
  } stack_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RD   = 1'b1
  } stack_state_t;

endpackage

// File: rtl/stack_ctl_fsm.sv
// Read sequencer for stack_ctl: IDLE/RD states, RD_LAT wait counter and registered req_ready.
module stack_ctl_fsm
  import stack_ctl_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic req_ready,
  output logic rd_last_c
);

  localparam int unsigned CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  stack_state_t   state, state_nx;
  logic [CW-1:0]  cnt, cnt_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      req_ready <= (state_nx == IDLE);
    end
  end

  // RD always waits the full read latency, then hands back to IDLE.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    rd_last_c = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RD;
          cnt_nx   = '0;
        end
      end
      RD: begin
        if (cnt == CW'(RD_LAT - 1)) begin
          rd_last_c = 1'b1;
          state_nx  = IDLE;
          cnt_nx    = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: rtl/stack_ctl.sv
// TOS-cached stack front-end: TOS in a register, NOS and below in an external stack RAM.
// Optional high-water-mark output enabled by defining STACK_HWM_EN.
module stack_ctl
  import stack_ctl_pkg::*;
#(
  parameter int unsigned DEPTH  = STACK_DEPTH,
  parameter int unsigned DSZ    = STACK_DSZ,
  parameter int unsigned SSZ    = $clog2(DEPTH),
  parameter int unsigned RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  stack_op_t       req_op,
  input  logic [DSZ-1:0]  req_vi,
  output logic [DSZ-1:0]  tos,
  output logic [SSZ:0]    depth,
  output logic            empty,
  output logic            full,
  output logic            ovf,
  output logic            unf,
  input  logic            err_clr,
`ifdef STACK_HWM_EN
  output logic [SSZ:0]    hwm,
`endif
  output logic            ram_en,
  output stack_op_t       ram_op,
  output logic [SSZ-1:0]  ram_sp,
  output logic [DSZ-1:0]  ram_vi,
  input  logic [DSZ-1:0]  ram_q
);

  localparam int unsigned DW = SSZ + 1;

  logic [DSZ-1:0] tos_nx;
  logic [DW-1:0]  depth_nx;
  logic [SSZ-1:0] rd_sp;
  logic           ovf_set, unf_set, pop_start, rd_last_c;

  assign empty = (depth == '0);
  assign full  = (depth == DW'(DEPTH));

  stack_ctl_fsm #(.RD_LAT(RD_LAT)) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .start     (pop_start),
    .req_ready (req_ready),
    .rd_last_c (rd_last_c)
  );

  // Op decode, RAM request drive and next TOS/depth. NOS lives at depth-2.
  always_comb begin
    tos_nx    = tos;
    depth_nx  = depth;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    pop_start = 1'b0;
    ram_en    = 1'b0;
    ram_op    = NOP;
    ram_sp    = '0;
    ram_vi    = '0;
    if (!req_ready) begin
      ram_en = 1'b1;
      ram_op = POP;
      ram_sp = rd_sp;
      if (rd_last_c) begin
        tos_nx   = ram_q;
        depth_nx = depth - DW'(1);
      end
    end else if (req_valid) begin
      case (req_op)
        PUSH: begin
          if (full) begin
            ovf_set = 1'b1;
          end else begin
            if (!empty) begin
              ram_en = 1'b1;
              ram_op = PUSH;
              ram_sp = SSZ'(depth - DW'(1));
              ram_vi = tos;
            end
            tos_nx   = req_vi;
            depth_nx = depth + DW'(1);
          end
        end
        POP: begin
          if (empty) begin
            unf_set = 1'b1;
          end else if (depth == DW'(1)) begin
            tos_nx   = '0;
            depth_nx = '0;
          end else begin
            ram_en    = 1'b1;
            ram_op    = POP;
            ram_sp    = SSZ'(depth - DW'(2));
            pop_start = 1'b1;
          end
        end
        REPL: begin
          if (empty) unf_set = 1'b1;
          else       tos_nx  = req_vi;
        end
        default: ;
      endcase
    end
  end

  // A new error in the same cycle as err_clr keeps its flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      tos   <= '0;
      depth <= '0;
      rd_sp <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      tos   <= tos_nx;
      depth <= depth_nx;
      if (pop_start) rd_sp <= ram_sp;
      ovf   <= ovf_set | (ovf & ~err_clr);
      unf   <= unf_set | (unf & ~err_clr);
    end
  end

`ifdef STACK_HWM_EN
  always_ff @(posedge clk) begin
    if (rst)              hwm <= '0;
    else if (depth > hwm) hwm <= depth;
  end
`endif

endmodule
